// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: FSM state encoding and owner IDs.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_HST = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that was not served
// last wins; otherwise the single eligible requester wins.
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic elig_cpu,
  input  logic elig_hst,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  // Select the winner from the eligibility bits and the previous owner
  always_comb begin
    valid  = elig_cpu | elig_hst;
    winner = OWN_CPU;
    if (elig_cpu && elig_hst) begin
      winner = ~last_owner;
    end else if (elig_hst) begin
      winner = OWN_HST;
    end else begin
      winner = OWN_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one single-port synchronous memory between the CPU
// datapath and the host loader/debug port, one access in flight at a time.
// Each access takes IDLE -> ISSUE -> WAIT; the host lock removes the CPU
// from arbitration and stalls its sequence counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          hst_req,
  input  logic          hst_we,
  input  logic [AW-1:0] hst_addr,
  input  logic [DW-1:0] hst_wdata,
  output logic          hst_gnt,
  output logic          hst_done,
  output logic [DW-1:0] hst_rdata,
  input  logic          hst_lock,
  output logic          cpu_stall,
  output logic [AW-1:0] mem_ad,
  output logic          mem_we,
  output logic [DW-1:0] mem_idat,
  input  logic [DW-1:0] mem_dat
);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          owner;       // also serves as last_owner for arbitration
  logic          owner_nxt;
  logic          op_we;       // remembers whether the access in flight writes
  logic          op_we_nxt;
  logic          elig_cpu;
  logic          elig_hst;
  logic          pick_valid;
  logic          pick_winner;

  logic          cpu_gnt_nxt;
  logic          cpu_done_nxt;
  logic [DW-1:0] cpu_rdata_nxt;
  logic          hst_gnt_nxt;
  logic          hst_done_nxt;
  logic [DW-1:0] hst_rdata_nxt;
  logic [AW-1:0] mem_ad_nxt;
  logic          mem_we_nxt;
  logic [DW-1:0] mem_idat_nxt;

  // The CPU drops out of arbitration the same cycle the lock is raised
  assign elig_cpu = cpu_req & ~hst_lock;
  assign elig_hst = hst_req;

  rr_pick2 u_pick (
    .elig_cpu   (elig_cpu),
    .elig_hst   (elig_hst),
    .last_owner (owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: requests are only considered in IDLE
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = pick_valid ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and access context
  always_comb begin
    cpu_gnt_nxt   = 1'b0;
    cpu_done_nxt  = 1'b0;
    hst_gnt_nxt   = 1'b0;
    hst_done_nxt  = 1'b0;
    mem_we_nxt    = 1'b0;
    cpu_rdata_nxt = cpu_rdata;
    hst_rdata_nxt = hst_rdata;
    mem_ad_nxt    = mem_ad;
    mem_idat_nxt  = mem_idat;
    owner_nxt     = owner;
    op_we_nxt     = op_we;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_nxt = pick_winner;
          if (pick_winner == OWN_HST) begin
            hst_gnt_nxt  = 1'b1;
            mem_ad_nxt   = hst_addr;
            mem_we_nxt   = hst_we;
            mem_idat_nxt = hst_wdata;
            op_we_nxt    = hst_we;
          end else begin
            cpu_gnt_nxt  = 1'b1;
            mem_ad_nxt   = cpu_addr;
            mem_we_nxt   = cpu_we;
            mem_idat_nxt = cpu_wdata;
            op_we_nxt    = cpu_we;
          end
        end else begin
          mem_we_nxt = 1'b0;
        end
      end
      ST_ISSUE: begin
        mem_we_nxt = 1'b0;
      end
      ST_WAIT: begin
        // mem_dat now holds the word addressed during ISSUE
        if (owner == OWN_HST) begin
          hst_done_nxt = 1'b1;
          if (!op_we) begin
            hst_rdata_nxt = mem_dat;
          end else begin
            hst_rdata_nxt = hst_rdata;
          end
        end else begin
          cpu_done_nxt = 1'b1;
          if (!op_we) begin
            cpu_rdata_nxt = mem_dat;
          end else begin
            cpu_rdata_nxt = cpu_rdata;
          end
        end
      end
      default: begin
        mem_we_nxt = 1'b0;
      end
    endcase
  end

  // Output and access-context registers; reset leaves the host as last owner
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_gnt   <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_rdata <= {DW{1'b0}};
      hst_gnt   <= 1'b0;
      hst_done  <= 1'b0;
      hst_rdata <= {DW{1'b0}};
      mem_ad    <= {AW{1'b0}};
      mem_we    <= 1'b0;
      mem_idat  <= {DW{1'b0}};
      owner     <= OWN_HST;
      op_we     <= 1'b0;
    end else begin
      cpu_gnt   <= cpu_gnt_nxt;
      cpu_done  <= cpu_done_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      hst_gnt   <= hst_gnt_nxt;
      hst_done  <= hst_done_nxt;
      hst_rdata <= hst_rdata_nxt;
      mem_ad    <= mem_ad_nxt;
      mem_we    <= mem_we_nxt;
      mem_idat  <= mem_idat_nxt;
      owner     <= owner_nxt;
      op_we     <= op_we_nxt;
    end
  end

  // CPU stall follows the host lock one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_stall <= 1'b0;
    end else begin
      cpu_stall <= hst_lock;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model, a reference model that
// predicts service order and read data, and a monitor that checks every
// grant/done pulse against the expectation queues.
module tb_mem_arbiter;

  localparam logic C = 1'b0;
  localparam logic H = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, hst_req, hst_we, hst_lock;
  logic [7:0]  cpu_addr, hst_addr;
  logic [15:0] cpu_wdata, hst_wdata;
  logic        cpu_gnt, cpu_done, hst_gnt, hst_done, cpu_stall, mem_we;
  logic [15:0] cpu_rdata, hst_rdata, mem_idat, mem_dat;
  logic [7:0]  mem_ad;

  int checks = 0;
  int errors = 0;

  // memory and reference model
  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  logic        preload;
  logic        m_last;
  logic [15:0] m_cpu_rd, m_hst_rd;

  // scoreboard queues
  logic        gnt_q[$];
  logic        done_who_q[$];
  logic [15:0] done_rd_q[$];
  string       chk_name_q[$];
  logic [31:0] chk_act_q[$];
  logic [31:0] chk_exp_q[$];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(8), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_wdata(hst_wdata),
    .hst_gnt(hst_gnt), .hst_done(hst_done), .hst_rdata(hst_rdata),
    .hst_lock(hst_lock), .cpu_stall(cpu_stall),
    .mem_ad(mem_ad), .mem_we(mem_we), .mem_idat(mem_idat), .mem_dat(mem_dat)
  );

  // synchronous single-port memory; preload copies the reference image
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
      mem_dat <= 16'h0000;
    end else begin
      if (mem_we) mem[mem_ad] <= mem_idat;
      mem_dat <= mem[mem_ad];
    end
  end

  task automatic push_chk(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_name_q.push_back(n);
    chk_act_q.push_back(a);
    chk_exp_q.push_back(e);
  endtask

  // reference model: one access by 'who', served in the order of the calls
  task automatic expect_access(input logic who, input logic we, input logic [7:0] a,
                               input logic [15:0] d);
    if (we) ref_mem[a] = d;
    else if (who == H) m_hst_rd = ref_mem[a];
    else m_cpu_rd = ref_mem[a];
    gnt_q.push_back(who);
    done_who_q.push_back(who);
    done_rd_q.push_back(who == H ? m_hst_rd : m_cpu_rd);
    m_last = who;
  endtask

  // both present together: whoever was not served last goes first
  task automatic model_round(input bit c_on, input bit h_on,
                             input logic c_we, input logic [7:0] c_a, input logic [15:0] c_d,
                             input logic h_we, input logic [7:0] h_a, input logic [15:0] h_d);
    if (c_on && h_on) begin
      if (m_last == H) begin
        expect_access(C, c_we, c_a, c_d);
        expect_access(H, h_we, h_a, h_d);
      end else begin
        expect_access(H, h_we, h_a, h_d);
        expect_access(C, c_we, c_a, c_d);
      end
    end else if (c_on) begin
      expect_access(C, c_we, c_a, c_d);
    end else begin
      expect_access(H, h_we, h_a, h_d);
    end
  endtask

  task automatic cpu_wait();
    int n = 0;
    while (!cpu_gnt && n < 200) begin @(negedge clk); n++; end
    cpu_req = 1'b0;
    if (!cpu_gnt) push_chk("cpu_gnt_timeout", 32'd1, 32'd0);
    n = 0;
    while (!cpu_done && n < 10) begin @(negedge clk); n++; end
    if (!cpu_done) push_chk("cpu_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_cpu(input logic we, input logic [7:0] a, input logic [15:0] d);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    cpu_wait();
  endtask

  task automatic do_hst(input logic we, input logic [7:0] a, input logic [15:0] d);
    int n = 0;
    hst_we = we; hst_addr = a; hst_wdata = d; hst_req = 1'b1;
    while (!hst_gnt && n < 200) begin @(negedge clk); n++; end
    hst_req = 1'b0;
    if (!hst_gnt) push_chk("hst_gnt_timeout", 32'd1, 32'd0);
    n = 0;
    while (!hst_done && n < 10) begin @(negedge clk); n++; end
    if (!hst_done) push_chk("hst_done_timeout", 32'd1, 32'd0);
  endtask

  task automatic model_reset();
    m_last = H; m_cpu_rd = 16'h0000; m_hst_rd = 16'h0000;
  endtask

  // monitor state (written only by the monitor)
  int          cyc = 0;
  int          last_gnt_cyc = -100;
  int          we_run = 0;
  logic        exp_who;
  logic [15:0] exp_rd;

  // monitor: drains direct checks and scores every grant/done pulse
  always @(negedge clk) begin
    cyc = cyc + 1;
    while (chk_name_q.size() > 0) begin
      string n;
      logic [31:0] a, e;
      n = chk_name_q.pop_front(); a = chk_act_q.pop_front(); e = chk_exp_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
    end
    if (mem_we) we_run++;
    else if (we_run != 0) begin
      checks++;
      if (we_run != 1) begin errors++; $display("FAIL mem_we_width: got %0d cycles expected 1", we_run); end
      we_run = 0;
    end
    if (!reset) begin
      if (cpu_gnt || hst_gnt) begin
        checks++;
        if (cpu_gnt && hst_gnt) begin
          errors++; $display("FAIL both_gnt: got cpu_gnt=1 hst_gnt=1 expected one");
        end else if (gnt_q.size() == 0) begin
          errors++; $display("FAIL unexpected_gnt: got hst_gnt=%0d expected none", hst_gnt);
        end else begin
          exp_who = gnt_q.pop_front();
          if (hst_gnt !== exp_who) begin
            errors++; $display("FAIL gnt_owner: got %0d expected %0d (0=cpu 1=hst)", hst_gnt, exp_who);
          end
        end
        checks++;
        if (cyc - last_gnt_cyc < 3) begin
          errors++; $display("FAIL gnt_spacing: got %0d expected >=3", cyc - last_gnt_cyc);
        end
        last_gnt_cyc = cyc;
      end
      if (cpu_done || hst_done) begin
        checks++;
        if (cpu_done && hst_done) begin
          errors++; $display("FAIL both_done: got cpu_done=1 hst_done=1 expected one");
        end else if (done_who_q.size() == 0) begin
          errors++; $display("FAIL unexpected_done: got hst_done=%0d expected none", hst_done);
        end else begin
          exp_who = done_who_q.pop_front();
          exp_rd  = done_rd_q.pop_front();
          if (hst_done !== exp_who) begin
            errors++; $display("FAIL done_owner: got %0d expected %0d", hst_done, exp_who);
          end else if ((hst_done ? hst_rdata : cpu_rdata) !== exp_rd) begin
            errors++; $display("FAIL rdata: got %h expected %h (owner %0d)",
                               hst_done ? hst_rdata : cpu_rdata, exp_rd, hst_done);
          end
        end
        checks++;
        if (cyc - last_gnt_cyc != 2) begin
          errors++; $display("FAIL done_latency: got %0d expected 2", cyc - last_gnt_cyc);
        end
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] wd [4];
  int          t_gnt [4];
  int          ng;
  int          seen;
  logic [15:0] old10;

  // stimulus
  initial begin
    reset = 1'b1; preload = 1'b1; hst_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
    hst_req = 1'b0; hst_we = 1'b0; hst_addr = 8'h00; hst_wdata = 16'h0000;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
    ref_mem[8'h05] = 16'h1234;
    if (ref_mem[8'h10] == 16'hDEAD) ref_mem[8'h10] = 16'h5A5A;
    old10 = ref_mem[8'h10];
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    // reset values
    push_chk("rst_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
    push_chk("rst_hst_gnt", {31'd0, hst_gnt}, 32'd0);
    push_chk("rst_dones", {30'd0, cpu_done, hst_done}, 32'd0);
    push_chk("rst_rdata", {cpu_rdata, hst_rdata}, 32'd0);
    push_chk("rst_mem_bus", {7'd0, mem_we, mem_ad, mem_idat}, 32'd0);
    push_chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    reset = 1'b0;

    // CPU read of preloaded word; host side stays quiet
    expect_access(C, 1'b0, 8'h05, 16'h0000);
    do_cpu(1'b0, 8'h05, 16'h0000);
    push_chk("hst_rdata_quiet", {16'd0, hst_rdata}, 32'd0);

    // reset in ISSUE of a host write
    gnt_q.push_back(H);
    hst_we = 1'b1; hst_addr = 8'h10; hst_wdata = 16'hDEAD; hst_req = 1'b1;
    ng = 0;
    while (!hst_gnt && ng < 20) begin @(negedge clk); ng++; end
    hst_req = 1'b0;
    push_chk("issue_mem_we", {31'd0, mem_we}, 32'd1);
    #2 reset = 1'b1;
    #1 push_chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // both held: grants alternate CPU, HST, CPU, HST, 3 cycles apart
    for (int k = 0; k < 4; k++) expect_access(k[0] ? H : C, 1'b0, k[0] ? 8'h06 : 8'h05, 16'h0000);
    cpu_we = 1'b0; cpu_addr = 8'h05; hst_we = 1'b0; hst_addr = 8'h06;
    cpu_req = 1'b1; hst_req = 1'b1;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk);
      if (cpu_gnt || hst_gnt) begin t_gnt[ng] = i; ng++; end
    end
    cpu_req = 1'b0; hst_req = 1'b0;
    push_chk("alt_grant_count", ng, 32'd4);
    for (int k = 0; k < 3; k++) push_chk("alt_gnt_gap", t_gnt[k+1] - t_gnt[k], 32'd3);
    repeat (3) @(negedge clk);

    // the aborted write never landed
    expect_access(H, 1'b0, 8'h10, 16'h0000);
    do_hst(1'b0, 8'h10, 16'h0000);
    push_chk("old_value_0x10", {16'd0, ref_mem[8'h10]}, {16'd0, old10});

    // host write then CPU read of the same word
    expect_access(H, 1'b1, 8'h20, 16'hBEEF);
    do_hst(1'b1, 8'h20, 16'hBEEF);
    expect_access(C, 1'b0, 8'h20, 16'h0000);
    do_cpu(1'b0, 8'h20, 16'h0000);

    // lock raised while a CPU read is in ISSUE
    for (int k = 0; k < 4; k++) wd[k] = 16'($urandom);
    expect_access(C, 1'b0, 8'h30, 16'h0000);
    for (int k = 0; k < 4; k++) expect_access(H, 1'b1, 8'(k), wd[k]);
    expect_access(C, 1'b0, 8'h02, 16'h0000);
    cpu_we = 1'b0; cpu_addr = 8'h30; cpu_req = 1'b1;
    ng = 0;
    while (!cpu_gnt && ng < 20) begin @(negedge clk); ng++; end
    hst_lock = 1'b1;
    cpu_addr = 8'h02;
    fork
      begin
        int n = 0;
        @(negedge clk);
        push_chk("stall_on", {31'd0, cpu_stall}, 32'd1);
        while (!cpu_done && n < 10) begin @(negedge clk); n++; end
        push_chk("inflight_done", {31'd0, cpu_done}, 32'd1);
      end
      begin
        for (int k = 0; k < 4; k++) do_hst(1'b1, 8'(k), wd[k]);
      end
    join
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_gnt) seen++;
    end
    push_chk("no_cpu_gnt_locked", seen, 32'd0);
    push_chk("stall_held", {31'd0, cpu_stall}, 32'd1);
    hst_lock = 1'b0;
    @(negedge clk);
    push_chk("stall_off", {31'd0, cpu_stall}, 32'd0);
    cpu_wait();

    // top address, no wrap into 8'h00
    expect_access(C, 1'b1, 8'hFF, 16'h00FF);
    do_cpu(1'b1, 8'hFF, 16'h00FF);
    expect_access(H, 1'b0, 8'hFF, 16'h0000);
    do_hst(1'b0, 8'hFF, 16'h0000);
    expect_access(C, 1'b0, 8'h00, 16'h0000);
    do_cpu(1'b0, 8'h00, 16'h0000);

    // randomized rounds against the reference model
    for (int r = 0; r < 40; r++) begin
      int          mode;
      logic        cw, hw;
      logic [7:0]  ca, ha;
      logic [15:0] cd, hd;
      mode = $urandom_range(1, 3);
      cw = 1'($urandom); hw = 1'($urandom);
      ca = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      ha = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      cd = 16'($urandom); hd = 16'($urandom);
      model_round(mode[0], mode[1], cw, ca, cd, hw, ha, hd);
      fork
        begin if (mode[0]) do_cpu(cw, ca, cd); end
        begin if (mode[1]) do_hst(hw, ha, hd); end
      join
    end

    repeat (5) @(negedge clk);
    push_chk("leftover_done", done_who_q.size(), 32'd0);
    push_chk("leftover_gnt", gnt_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port 256x16 program/data memory between the CPU datapath and a host loader/debug port.
- Two requesters. Only one access is outstanding at a time. Round-robin arbitration, plus a host lock that freezes the CPU while the host owns memory.
- Sits between the CPU control logic and the memory: drives the memory address, write enable and write data; returns read data to the requester it is serving.

Parameters:
- AW, 8, memory address width (matches AR/PC width)
- DW, 16, memory data width (matches AC/DR/IR width)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, level
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address (AR)
- cpu_wdata  in  DW  CPU write data (AC)
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted
- cpu_done  out  1  one-cycle pulse: CPU access complete
- cpu_rdata  out  DW  read data, valid while cpu_done is high
- hst_req, hst_we, hst_addr, hst_wdata  in  1/1/AW/DW  same meaning, host side
- hst_gnt, hst_done, hst_rdata  out  1/1/DW  same meaning, host side
- hst_lock  in  1  host requests exclusive ownership
- cpu_stall  out  1  CPU must hold its sequence counter (drives its enable low)
- mem_ad  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_idat  out  DW  memory write data
- mem_dat  in  DW  memory read data, synchronous: valid the cycle after the address is sampled

Behaviour:
- Reset: all outputs are 0. State = IDLE. last_owner = HST, so the CPU wins the first tie. cpu_stall = 0.
- States: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE:
  - Requests are sampled only in IDLE.
  - Eligible = hst_req, plus cpu_req when hst_lock = 0.
  - If both are eligible, grant the requester that is not last_owner.
  - On a grant: register mem_ad, mem_we and mem_idat from the winner; pulse the winner's gnt; set last_owner; go to ISSUE.
  - If nothing is eligible, stay in IDLE with mem_we = 0.
- ISSUE: memory samples mem_ad/mem_we/mem_idat at the end of this cycle. Go to WAIT. mem_we drops to 0 on the transition.
- WAIT: capture mem_dat into the owner's rdata (reads only; writes leave rdata unchanged). Pulse the owner's done in the following cycle. Go to IDLE.
- Timing: request sampled at edge E0 -> gnt high in cycle 1 -> memory access at E1 -> done and rdata valid in cycle 3. A new request can be sampled at E3. Peak throughput is one access per 3 cycles.
- Request hold: the requester holds req/we/addr/wdata stable until gnt. It must deassert req by the cycle after gnt unless it wants another access. A req still high when IDLE samples it is a new access.
- Non-owner: gnt, done and rdata of the non-owner are unaffected.
- Lock:
  - cpu_stall is registered. It is 1 from the cycle after hst_lock rises until the cycle after hst_lock falls.
  - An in-flight CPU access completes normally.
  - A CPU request arriving while locked waits; it is never dropped.
- Simultaneous events:
  - hst_lock rising on the same cycle IDLE evaluates: the CPU is not eligible.
  - Both requests high every window: grants alternate CPU, HST, CPU, ...
- Reset mid-operation:
  - Asynchronous return to IDLE. mem_we clears immediately. No gnt/done pulse is generated.
  - A write is committed only if mem_we was high at a non-reset clock edge.
  - Memory contents are not cleared.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2
  - owner IDs OWN_CPU = 1'b0, OWN_HST = 1'b1
- One sub-module, rr_pick2: combinational two-way round-robin picker. Inputs: two eligibility bits and last_owner. Outputs: a valid bit and the winner ID.
- The FSM, output registers and lock logic live in mem_arbiter.

Test Plan:
- Reset during ISSUE of a host write (addr 8'h10, data 16'hDEAD) -> mem_we = 0 immediately, no hst_done, and a later read of 8'h10 returns its old value.
- CPU read of 8'h05, memory preloaded with 16'h1234 -> cpu_gnt in cycle 1, cpu_done with cpu_rdata = 16'h1234 in cycle 3, hst outputs stay 0.
- Host write 16'hBEEF to 8'h20, then CPU read of 8'h20 -> cpu_rdata = 16'hBEEF; mem_we high for exactly one cycle.
- cpu_req and hst_req both held high for 4 grants after reset -> grant order CPU, HST, CPU, HST, with gnt pulses 3 cycles apart.
- hst_lock raised while a CPU read is in ISSUE -> that read completes with done; cpu_stall = 1 the next cycle; a held cpu_req gets no grant while host writes 8'h00..8'h03 proceed; after the lock drops, the CPU is granted and cpu_stall = 0.
- Write 16'h00FF to 8'hFF (top address), then read it back -> rdata = 16'h00FF, no address wrap or corruption of 8'h00.
